button_debouncer: RTL and testbench

//   Input-side companion to the LED flasher: conditions a raw, bouncing push-button

---
 rtl/button_debouncer.sv | 147 ++++++++++++++
 tb/tb_button_debouncer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Conditions a raw bouncing push-button pad into a debounced
//               pressed level, single-cycle press / release / long-press
//               events and an 8-bit wrapping press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int CLOCK_FREQUENCY = 12_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int LONGPRESS_MS    = 1000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       i_btn,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic [7:0] o_count
);

    localparam int c_DB_TICKS = CLOCK_FREQUENCY / 1000 * DEBOUNCE_MS;
    localparam int c_LP_TICKS = CLOCK_FREQUENCY / 1000 * LONGPRESS_MS;
    localparam int c_DB_W     = (c_DB_TICKS > 1) ? $clog2(c_DB_TICKS) : 1;
    localparam int c_LP_W     = (c_LP_TICKS > 1) ? $clog2(c_LP_TICKS) : 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(c_DB_TICKS - 1);
    localparam logic [c_LP_W-1:0] c_LP_LAST = c_LP_W'(c_LP_TICKS - 1);

    // Pad level seen while the button is released
    localparam logic c_IDLE_PAD = ACTIVE_LOW ? 1'b1 : 1'b0;

    // Reject timing parameters that cannot form a meaningful debounce/hold
    if ((c_DB_TICKS < 2) || (c_LP_TICKS <= c_DB_TICKS)) begin : g_bad_params
        $error("button_debouncer: need DB_TICKS >= 2 and LP_TICKS > DB_TICKS");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_PRESSED    = 3'd2,
        S_LONG_HELD  = 3'd3,
        S_DB_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_ret_long;   // state to resume after a rejected release bounce
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_LP_W-1:0]   r_hold_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_p;

    // Two-flop synchronizer for the asynchronous pad
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_sync1 <= c_IDLE_PAD;
            r_sync2 <= c_IDLE_PAD;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Pressed = 1 regardless of pad polarity
    assign w_p = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // Debounce / hold state machine with registered event outputs
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ret_long <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            o_level    <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_long     <= 1'b0;
            o_count    <= 8'd0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_p) begin
                        r_state  <= S_DB_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                S_DB_PRESS: begin
                    if (!w_p) begin
                        r_state <= S_IDLE;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state    <= S_PRESSED;
                        o_level    <= 1'b1;
                        o_press    <= 1'b1;
                        o_count    <= o_count + 8'd1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    // A release takes priority over reaching the hold terminal count
                    if (!w_p) begin
                        r_state    <= S_DB_RELEASE;
                        r_db_cnt   <= '0;
                        r_ret_long <= 1'b0;
                    end else if (r_hold_cnt == c_LP_LAST) begin
                        r_state <= S_LONG_HELD;
                        o_long  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_LONG_HELD: begin
                    if (!w_p) begin
                        r_state    <= S_DB_RELEASE;
                        r_db_cnt   <= '0;
                        r_ret_long <= 1'b1;
                    end
                end
                S_DB_RELEASE: begin
                    // hold_cnt is left untouched so a rejected bounce resumes timing
                    if (w_p) begin
                        r_state <= r_ret_long ? S_LONG_HELD : S_PRESSED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state   <= S_IDLE;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer. A run-length model
//               of the debounce rules is compared against the DUT every
//               cycle; directed scenarios pin exact latencies and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int DB = 8;
    localparam int LP = 40;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic       i_btn  = 1'b1;
    logic       o_level, o_press, o_release, o_long;
    logic [7:0] o_count;

    button_debouncer #(
        .CLOCK_FREQUENCY(4000),
        .DEBOUNCE_MS    (2),
        .LONGPRESS_MS   (10),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .refclk   (refclk),
        .reset    (reset),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_count  (o_count)
    );

    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pressed state of the pad reaches the decision logic two edges late.
    // A level change is accepted once DB+1 consecutive decision samples
    // disagree with the current level. Hold time counts decision samples that
    // are pressed while no release is pending.
    bit m_valid = 0;
    bit dly[2];
    bit lvl;
    int run, hold;
    bit long_done;
    int m_count;
    bit m_press, m_release, m_long;

    always @(posedge refclk) begin
        bit p;
        if (reset) begin
            dly[0] = 0; dly[1] = 0;
            lvl = 0; run = 0; hold = 0; long_done = 0; m_count = 0;
            m_press = 0; m_release = 0; m_long = 0;
            m_valid = 1;
        end else begin
            p = dly[1];
            dly[1] = dly[0];
            dly[0] = ~i_btn;
            m_press = 0; m_release = 0; m_long = 0;
            if (p != lvl) begin
                run++;
                if (run == DB + 1) begin
                    lvl = p;
                    run = 0;
                    if (lvl) begin
                        m_press = 1;
                        m_count = (m_count + 1) % 256;
                        hold = 0;
                        long_done = 0;
                    end else begin
                        m_release = 1;
                    end
                end
            end else begin
                if (lvl && run == 0 && !long_done) begin
                    hold++;
                    if (hold == LP) begin
                        m_long = 1;
                        long_done = 1;
                    end
                end
                run = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge refclk) begin
        if (m_valid) begin
            check("level",   int'(o_level),   int'(lvl));
            check("press",   int'(o_press),   int'(m_press));
            check("release", int'(o_release), int'(m_release));
            check("long",    int'(o_long),    int'(m_long));
            check("count",   int'(o_count),   m_count);
        end
    end

    // ---------------- directed helpers ----------------
    int cyc, press_cnt, rel_cnt, long_cnt, first_press, first_rel, first_long;

    task automatic clear_marks();
        cyc = 0; press_cnt = 0; rel_cnt = 0; long_cnt = 0;
        first_press = -1; first_rel = -1; first_long = -1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge refclk);
            cyc++;
            if (o_press)   begin press_cnt++; if (first_press < 0) first_press = cyc; end
            if (o_release) begin rel_cnt++;   if (first_rel   < 0) first_rel   = cyc; end
            if (o_long)    begin long_cnt++;  if (first_long  < 0) first_long  = cyc; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_btn = 1'b1;
        step(2);
        reset = 1'b0;
        clear_marks();
    endtask

    initial begin
        int mark;
        clear_marks();
        step(3);
        do_reset();
        check("reset_level", int'(o_level), 0);
        check("reset_count", int'(o_count), 0);

        // 1: clean press, held long enough for a long press, then clean release
        i_btn = 1'b0;
        step(100);
        check("t1_press_lat", first_press, 11);
        check("t1_long_lat",  first_long, 51);
        check("t1_press_cnt", press_cnt, 1);
        check("t1_long_cnt",  long_cnt, 1);
        check("t1_level",     int'(o_level), 1);
        check("t1_count",     int'(o_count), 1);
        check("t1_model_cnt", m_count, 1);
        clear_marks();
        i_btn = 1'b1;
        step(30);
        check("t1_rel_lat", first_rel, 11);
        check("t1_rel_cnt", rel_cnt, 1);
        check("t1_level_off", int'(o_level), 0);

        // 2: bouncy press
        do_reset();
        i_btn = 1'b0; step(5);
        i_btn = 1'b1; step(3);
        mark = cyc;
        i_btn = 1'b0; step(30);
        check("t2_press_cnt", press_cnt, 1);
        check("t2_press_lat", first_press - mark, 11);
        check("t2_count", int'(o_count), 1);

        // 3: short press with bouncy release
        do_reset();
        i_btn = 1'b0; step(20);
        i_btn = 1'b1; step(2);
        i_btn = 1'b0; step(3);
        mark = cyc;
        i_btn = 1'b1; step(30);
        check("t3_rel_cnt",  rel_cnt, 1);
        check("t3_rel_lat",  first_rel - mark, 11);
        check("t3_long_cnt", long_cnt, 0);
        check("t3_level",    int'(o_level), 0);

        // 4: glitch shorter than the debounce window
        do_reset();
        i_btn = 1'b0; step(6);
        i_btn = 1'b1; step(20);
        check("t4_press_cnt", press_cnt, 0);
        check("t4_level", int'(o_level), 0);
        check("t4_count", int'(o_count), 0);

        // 5: counter wrap after 256 presses
        do_reset();
        for (int k = 0; k < 256; k++) begin
            i_btn = 1'b0; step(15);
            i_btn = 1'b1; step(15);
            if (k == 254) check("t5_count_255", int'(o_count), 255);
        end
        check("t5_count_wrap", int'(o_count), 0);
        check("t5_press_cnt", press_cnt, 256);
        check("t5_rel_cnt", rel_cnt, 256);

        // 6: reset mid-hold with the button still held
        do_reset();
        i_btn = 1'b0; step(31);
        check("t6_level_before", int'(o_level), 1);
        reset = 1'b1; step(1);
        check("t6_level_rst", int'(o_level), 0);
        check("t6_count_rst", int'(o_count), 0);
        reset = 1'b0;
        clear_marks();
        step(20);
        check("t6_press_lat", first_press, 11);
        check("t6_count", int'(o_count), 1);

        // Random bursts around the debounce boundary plus long holds
        do_reset();
        for (int b = 0; b < 250; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end
            i_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step($urandom_range(40, 70));
            else step($urandom_range(1, 14));
        end
        i_btn = 1'b1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
